alu_seq: RTL and testbench

Parametrised, multi-cycle successor to the CPU datapath ALU. Executes single-cycle arithmetic/logic ops between the accumulator input and an internal operand register R. Adds shift ops, a status-flag output and an iterative shift-add multiply behind an en/busy/done handshake. Sits between the instruction register (opcode, en) and the accumulator (ac in, alu_out back).

---
 rtl/alu_pkg.sv | 29 ++
 rtl/alu_mul_seq.sv | 62 ++++++
 rtl/alu_seq.sv | 183 ++++++++++++++++++
 tb/tb_alu_seq.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the alu_seq datapath: opcode encodings, flag bit
// positions and the controller state type.
package alu_pkg;

  localparam logic [3:0] OP_MOVAC = 4'h0;
  localparam logic [3:0] OP_MOVR  = 4'h1;
  localparam logic [3:0] OP_ADD   = 4'h2;
  localparam logic [3:0] OP_SUB   = 4'h3;
  localparam logic [3:0] OP_INAC  = 4'h4;
  localparam logic [3:0] OP_CLAC  = 4'h5;
  localparam logic [3:0] OP_AND   = 4'h6;
  localparam logic [3:0] OP_OR    = 4'h7;
  localparam logic [3:0] OP_XNOR  = 4'h8;
  localparam logic [3:0] OP_NOT   = 4'h9;
  localparam logic [3:0] OP_SHL   = 4'hA;
  localparam logic [3:0] OP_SHR   = 4'hB;
  localparam logic [3:0] OP_MUL   = 4'hC;

  localparam int unsigned FLAG_Z = 3;
  localparam int unsigned FLAG_N = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  typedef enum logic {
    IDLE,
    MUL_RUN
  } alu_state_e;

endpackage

// File: rtl/alu_mul_seq.sv
// Iterative shift-add unsigned multiplier: one multiplier bit per cycle,
// WIDTH cycles after start. done/product are combinational during the last
// step so the parent can register the result on the same edge the last
// partial product is added.
module alu_mul_seq #(
  parameter int unsigned WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  logic               busy_q;
  logic [CW-1:0]      cnt_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [2*WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0]   mplier_q;
  logic [2*WIDTH-1:0] step_sum;

  // Partial-product accumulation for the current multiplier bit.
  always_comb begin
    step_sum = acc_q + (mplier_q[0] ? mcand_q : '0);
  end

  assign busy    = busy_q;
  assign done    = busy_q && (cnt_q == CNT_LAST);
  assign product = step_sum;

  // Operand capture on start, then one shift-add step per cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      busy_q   <= 1'b0;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
    end else if (start && !busy_q) begin
      busy_q   <= 1'b1;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= {{WIDTH{1'b0}}, a};
      mplier_q <= b;
    end else if (busy_q) begin
      acc_q    <= step_sum;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q + 1'b1;
      if (cnt_q == CNT_LAST) begin
        busy_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Accumulator-side ALU with internal operand register R, status flags and
// an optional multi-cycle multiply. Define ALU_MUL_EN to build in MUL, the
// MUL_RUN state and the alu_mul_seq multiplier; without it opcode C is
// illegal and busy is tied low.
module alu_seq
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned OPW   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [OPW-1:0]   operation,
  input  logic [WIDTH-1:0] ac,
  output logic [WIDTH-1:0] alu_out,
  output logic [3:0]       flags,
  output logic             busy,
  output logic             done,
  output logic             err
);

  logic [WIDTH-1:0] alu_out_q, alu_out_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [3:0]       flags_q, flags_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic             accept;
  logic [WIDTH-1:0] res;
  logic [3:0]       fl;
  logic             ill;
  logic [WIDTH:0]   add_w;
  logic [WIDTH:0]   inc_w;
  logic [WIDTH-1:0] sub_r;

  assign accept = en && !busy;

  // Single-cycle result and flags for the presented opcode.
  always_comb begin
    add_w = {1'b0, ac} + {1'b0, r_q};
    inc_w = {1'b0, ac} + {{WIDTH{1'b0}}, 1'b1};
    sub_r = ac - r_q;
    res   = '0;
    fl    = '0;
    ill   = 1'b0;
    case (operation)
      OP_MOVAC: res = ac;
      OP_MOVR:  res = r_q;
      OP_ADD: begin
        res         = add_w[WIDTH-1:0];
        fl[FLAG_C]  = add_w[WIDTH];
        fl[FLAG_V]  = (ac[WIDTH-1] == r_q[WIDTH-1]) && (res[WIDTH-1] != ac[WIDTH-1]);
      end
      OP_SUB: begin
        res         = sub_r;
        fl[FLAG_C]  = (ac < r_q);
        fl[FLAG_V]  = (ac[WIDTH-1] != r_q[WIDTH-1]) && (res[WIDTH-1] != ac[WIDTH-1]);
      end
      OP_INAC: begin
        res         = inc_w[WIDTH-1:0];
        fl[FLAG_C]  = inc_w[WIDTH];
        fl[FLAG_V]  = !ac[WIDTH-1] && res[WIDTH-1];
      end
      OP_CLAC:  res = '0;
      OP_AND:   res = ac & r_q;
      OP_OR:    res = ac | r_q;
      OP_XNOR:  res = ~ac ^ r_q;
      OP_NOT:   res = ~ac;
      OP_SHL: begin
        res         = ac << 1;
        fl[FLAG_C]  = ac[WIDTH-1];
      end
      OP_SHR: begin
        res         = ac >> 1;
        fl[FLAG_C]  = ac[0];
      end
`ifdef ALU_MUL_EN
      OP_MUL:   res = '0;
`endif
      default:  ill = 1'b1;
    endcase
    if (ill) begin
      res = '0;
      fl  = '0;
      fl[FLAG_Z] = 1'b1;
    end else begin
      fl[FLAG_Z] = (res == '0);
      fl[FLAG_N] = res[WIDTH-1];
    end
  end

`ifdef ALU_MUL_EN
  alu_state_e         state_q, state_d;
  logic               mul_start;
  logic               mul_busy;
  logic               mul_done;
  logic [2*WIDTH-1:0] mul_product;

  alu_mul_seq #(
    .WIDTH (WIDTH)
  ) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (mul_start),
    .a       (ac),
    .b       (r_q),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_product)
  );

  assign busy = mul_busy;

  // Controller state register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end
`else
  assign busy = 1'b0;
`endif

  // Next-state, commit of single-cycle results and multiply completion.
  always_comb begin
    alu_out_d = alu_out_q;
    flags_d   = flags_q;
    r_d       = r_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
`ifdef ALU_MUL_EN
    state_d   = state_q;
    mul_start = 1'b0;
    if (state_q == MUL_RUN && mul_done) begin
      alu_out_d       = mul_product[WIDTH-1:0];
      flags_d         = '0;
      flags_d[FLAG_Z] = (mul_product[WIDTH-1:0] == '0);
      flags_d[FLAG_N] = mul_product[WIDTH-1];
      flags_d[FLAG_C] = |mul_product[2*WIDTH-1:WIDTH];
      done_d          = 1'b1;
      state_d         = IDLE;
    end else if (accept && operation == OP_MUL) begin
      mul_start = 1'b1;
      state_d   = MUL_RUN;
    end else
`endif
    if (accept) begin
      alu_out_d = res;
      flags_d   = fl;
      done_d    = 1'b1;
      err_d     = ill;
      if (operation == OP_MOVAC) begin
        r_d = ac;
      end
    end
  end

  // Datapath registers; reset also aborts any multiply in flight.
  always_ff @(posedge clk) begin
    if (!rst) begin
      alu_out_q <= '0;
      flags_q   <= '0;
      r_q       <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      alu_out_q <= alu_out_d;
      flags_q   <= flags_d;
      r_q       <= r_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign alu_out = alu_out_q;
  assign flags   = flags_q;
  assign done    = done_q;
  assign err     = err_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq at WIDTH=8. MUL cases run only
// when ALU_MUL_EN is defined; otherwise opcode C is checked as illegal.
module tb_alu_seq;
  import alu_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic [3:0] operation = 4'h0;
  logic [7:0] ac = 8'h00;
  logic [7:0] alu_out;
  logic [3:0] flags;
  logic       busy;
  logic       done;
  logic       err;

  int checks = 0;
  int failures = 0;

  alu_seq #(
    .WIDTH (8),
    .OPW   (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .operation (operation),
    .ac        (ac),
    .alu_out   (alu_out),
    .flags     (flags),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one op for exactly one rising edge; returns 1 ns after that edge.
  task automatic do_op(input logic [3:0] o, input logic [7:0] a);
    @(negedge clk);
    en = 1'b1;
    operation = o;
    ac = a;
    @(posedge clk);
    #1;
    en = 1'b0;
  endtask

  task automatic chk_res(input string tag, input logic [7:0] out, input logic [3:0] fl,
                         input logic e);
    chk({tag, ".done"}, done, 1'b1);
    chk({tag, ".out"}, alu_out, out);
    chk({tag, ".flags"}, flags, fl);
    chk({tag, ".err"}, err, e);
  endtask

  initial begin
    // Reset held for two cycles
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.out", alu_out, 8'h00);
    chk("rst.flags", flags, 4'h0);
    chk("rst.busy", busy, 1'b0);
    chk("rst.done", done, 1'b0);
    chk("rst.err", err, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    tick();
    chk("post_rst.done", done, 1'b0);
    chk("post_rst.out", alu_out, 8'h00);

    // MOVAC then ADD on consecutive cycles: ADD sees updated R
    do_op(OP_MOVAC, 8'h7F); chk_res("movac7f", 8'h7F, 4'b0000, 1'b0);
    do_op(OP_ADD, 8'h01);   chk_res("add", 8'h80, 4'b0101, 1'b0);
    tick();
    chk("add.done_pulse", done, 1'b0);

    do_op(OP_MOVAC, 8'h05); chk_res("movac05", 8'h05, 4'b0000, 1'b0);
    do_op(OP_SUB, 8'h03);   chk_res("sub_borrow", 8'hFE, 4'b0110, 1'b0);
    do_op(OP_SHR, 8'h81);   chk_res("shr", 8'h40, 4'b0010, 1'b0);
    do_op(OP_SHL, 8'hC1);   chk_res("shl", 8'h82, 4'b0110, 1'b0);
    do_op(OP_INAC, 8'hFF);  chk_res("inac_wrap", 8'h00, 4'b1010, 1'b0);
    do_op(OP_INAC, 8'h7F);  chk_res("inac_ovf", 8'h80, 4'b0101, 1'b0);
    do_op(OP_MOVR, 8'hAA);  chk_res("movr", 8'h05, 4'b0000, 1'b0);
    do_op(OP_AND, 8'h0F);   chk_res("and", 8'h05, 4'b0000, 1'b0);
    do_op(OP_OR, 8'hF0);    chk_res("or", 8'hF5, 4'b0100, 1'b0);
    do_op(OP_XNOR, 8'h05);  chk_res("xnor", 8'hFF, 4'b0100, 1'b0);
    do_op(OP_NOT, 8'h0F);   chk_res("not", 8'hF0, 4'b0100, 1'b0);
    do_op(OP_CLAC, 8'h3C);  chk_res("clac", 8'h00, 4'b1000, 1'b0);
    do_op(OP_MOVAC, 8'h01);
    do_op(OP_SUB, 8'h80);   chk_res("sub_ovf", 8'h7F, 4'b0001, 1'b0);
    do_op(OP_ADD, 8'hFF);   chk_res("add_carry", 8'h00, 4'b1010, 1'b0);

    // Illegal opcode leaves R untouched
    do_op(4'hE, 8'h99);     chk_res("illegal_e", 8'h00, 4'b1000, 1'b1);
    tick();
    chk("illegal_e.err_pulse", err, 1'b0);
    chk("illegal_e.done_pulse", done, 1'b0);
    do_op(OP_MOVR, 8'h00);  chk_res("movr_after_ill", 8'h01, 4'b0000, 1'b0);

`ifdef ALU_MUL_EN
    // MUL 0x20 x 0x10 = 0x200: low half zero, high half nonzero
    do_op(OP_MOVAC, 8'h10);
    do_op(OP_MUL, 8'h20);
    chk("mul.busy_T", busy, 1'b1);
    chk("mul.done_T", done, 1'b0);
    for (int k = 1; k < 8; k++) begin
      @(negedge clk);
      if (k == 3) begin
        en = 1'b1;
        operation = OP_MOVAC;
        ac = 8'h55;
      end
      @(posedge clk);
      #1;
      en = 1'b0;
      chk($sformatf("mul.busy_%0d", k), busy, 1'b1);
      chk($sformatf("mul.done_%0d", k), done, 1'b0);
    end
    tick();
    chk("mul.busy_end", busy, 1'b0);
    chk_res("mul", 8'h00, 4'b1010, 1'b0);
    tick();
    chk("mul.done_pulse", done, 1'b0);
    do_op(OP_MOVR, 8'h00);  chk_res("movr_after_mul", 8'h10, 4'b0000, 1'b0);

    do_op(OP_MOVAC, 8'h03);
    do_op(OP_MUL, 8'h05);
    repeat (7) tick();
    chk("mul35.done_early", done, 1'b0);
    tick();
    chk_res("mul35", 8'h0F, 4'b0000, 1'b0);
    do_op(OP_MOVAC, 8'hFF);
    do_op(OP_MUL, 8'hFF);
    repeat (8) tick();
    chk_res("mulff", 8'h01, 4'b0010, 1'b0);

    // Reset mid-multiply aborts with no done
    do_op(OP_MUL, 8'h20);
    repeat (3) tick();
    @(negedge clk);
    rst = 1'b0;
    tick();
    chk("abort.busy", busy, 1'b0);
    chk("abort.out", alu_out, 8'h00);
    chk("abort.flags", flags, 4'h0);
    chk("abort.done", done, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    begin
      logic seen_done;
      seen_done = 1'b0;
      repeat (12) begin
        tick();
        if (done) seen_done = 1'b1;
      end
      chk("abort.no_done", seen_done, 1'b0);
    end
    do_op(OP_MOVR, 8'h00);  chk_res("abort.r_cleared", 8'h00, 4'b1000, 1'b0);
`else
    do_op(OP_MUL, 8'h12);   chk_res("mul_illegal", 8'h00, 4'b1000, 1'b1);
    chk("mul_illegal.busy", busy, 1'b0);
    tick();
    chk("mul_illegal.done_pulse", done, 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
